// File: rtl/expr_pkg.sv
// ============================================================================
// Module      : expr_pkg
// Description : Shared states, select codes and range limits for the
//               expression sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package expr_pkg;

    localparam int EXPR_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        ADD_B  = 3'd2,
        MUL_C  = 3'd3,
        SUB_D  = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    localparam logic signed [EXPR_WIDTH-1:0] EXPR_MAX = {1'b0, {(EXPR_WIDTH-1){1'b1}}};
    localparam logic signed [EXPR_WIDTH-1:0] EXPR_MIN = {1'b1, {(EXPR_WIDTH-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/expr_fit.sv
// ============================================================================
// Module      : expr_fit
// Description : Fits a full-precision step value into WIDTH signed bits and
//               flags out-of-range values. Wraps by default; clamps to the
//               signed limits when EXPR_SATURATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module expr_fit
    import expr_pkg::*;
#(
    parameter int WIDTH = EXPR_WIDTH
) (
    input  logic signed [2*WIDTH-1:0] full_i,
    output logic signed [WIDTH-1:0]   value_o,
    output logic                      ovf_o
);

    localparam logic signed [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // In range exactly when every bit above the result sign matches it.
    logic [WIDTH:0] w_upper;
    assign w_upper = full_i[2*WIDTH-1:WIDTH-1];
    assign ovf_o   = !((&w_upper) || (~|w_upper));

`ifdef EXPR_SATURATE_EN
    always_comb begin
        value_o = full_i[WIDTH-1:0];
        if (ovf_o) begin
            value_o = full_i[2*WIDTH-1] ? C_MIN : C_MAX;
        end
    end
`else
    assign value_o = full_i[WIDTH-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/expression_sequencer.sv
// ============================================================================
// Module      : expression_sequencer
// Description : Drives the operand mux select and evaluates ((A+B)*C)-D one
//               operand per cycle. Optional macro: EXPR_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module expression_sequencer
    import expr_pkg::*;
#(
    parameter int WIDTH = EXPR_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] mux_out,
    output logic [1:0]              select,
    output logic signed [WIDTH-1:0] result,
    output logic                    done,
    output logic                    busy,
    output logic                    overflow
);

    localparam int FW = 2 * WIDTH;

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] result_q, result_d;
    logic                    ovf_q, ovf_d;

    logic signed [FW-1:0]    fit_full;
    logic signed [WIDTH-1:0] fit_value;
    logic                    fit_ovf;

    expr_fit #(.WIDTH(WIDTH)) u_fit (
        .full_i  (fit_full),
        .value_o (fit_value),
        .ovf_o   (fit_ovf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    // One shared fit unit; each arithmetic state feeds it its own operation.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        fit_full = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_A;
                    ovf_d   = 1'b0;
                end
            end
            LOAD_A: begin
                acc_d   = mux_out;
                state_d = ADD_B;
            end
            ADD_B: begin
                fit_full = FW'(acc_q) + FW'(mux_out);
                acc_d    = fit_value;
                ovf_d    = ovf_q | fit_ovf;
                state_d  = MUL_C;
            end
            MUL_C: begin
                fit_full = FW'(acc_q) * FW'(mux_out);
                acc_d    = fit_value;
                ovf_d    = ovf_q | fit_ovf;
                state_d  = SUB_D;
            end
            SUB_D: begin
                fit_full = FW'(acc_q) - FW'(mux_out);
                result_d = fit_value;
                ovf_d    = ovf_q | fit_ovf;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the state register only, so select never glitches on inputs.
    always_comb begin
        select = SEL_A;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            LOAD_A: begin select = SEL_A; busy = 1'b1; end
            ADD_B:  begin select = SEL_B; busy = 1'b1; end
            MUL_C:  begin select = SEL_C; busy = 1'b1; end
            SUB_D:  begin select = SEL_D; busy = 1'b1; end
            DONE:   done = 1'b1;
            default: ;
        endcase
    end

    assign result   = result_q;
    assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_expression_sequencer.sv
// ============================================================================
// Module      : tb_expression_sequencer
// Description : Directed and random checks of expression_sequencer against an
//               arithmetic reference model. Honours EXPR_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_expression_sequencer;

    localparam int W = 16;
    localparam longint C_MAX = (64'sd1 <<< (W-1)) - 1;
    localparam longint C_MIN = -(64'sd1 <<< (W-1));

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic signed [W-1:0] mux_out;
    logic [1:0]          select;
    logic signed [W-1:0] result;
    logic                done, busy, overflow;

    logic signed [W-1:0] ops [4];

    int checks = 0;
    int errors = 0;

    expression_sequencer #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .mux_out  (mux_out),
        .select   (select),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clock = ~clock;
    always_comb mux_out = ops[select];

    task automatic check(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint fit_model(input longint v, inout bit ovf);
        logic signed [W-1:0] t;
        if (v > C_MAX || v < C_MIN) begin
            ovf = 1'b1;
`ifdef EXPR_SATURATE_EN
            return (v > C_MAX) ? C_MAX : C_MIN;
`endif
        end
        t = v[W-1:0];
        return longint'(t);
    endfunction

    function automatic void model(input longint a, b, c, d,
                                  output longint res, output bit ovf);
        longint v;
        ovf = 1'b0;
        v   = fit_model(a + b, ovf);
        v   = fit_model(v * c, ovf);
        res = fit_model(v - d, ovf);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full run with select/busy/done timing checks at every edge.
    task automatic run_eval(input string tag, input longint a, b, c, d);
        longint exp_res;
        bit     exp_ovf;
        model(a, b, c, d, exp_res, exp_ovf);
        ops[0] = W'(a); ops[1] = W'(b); ops[2] = W'(c); ops[3] = W'(d);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            check({tag, " select"}, longint'(select), longint'(s));
            check({tag, " busy"}, longint'(busy), 1);
            check({tag, " done low"}, longint'(done), 0);
            tick();
        end
        check({tag, " done"}, longint'(done), 1);
        check({tag, " busy at done"}, longint'(busy), 0);
        check({tag, " result"}, longint'(result), exp_res);
        check({tag, " overflow"}, longint'(overflow), longint'(exp_ovf));
        tick();
        check({tag, " done one cycle"}, longint'(done), 0);
        check({tag, " result hold"}, longint'(result), exp_res);
    endtask

    initial begin
        int     dcount;
        int     dcyc [$];
        longint ra, rb, rc, rd;

        for (int i = 0; i < 4; i++) ops[i] = '0;

        reset = 1'b1;
        #12;
        check("reset result", longint'(result), 0);
        check("reset select", longint'(select), 0);
        check("reset done", longint'(done), 0);
        check("reset busy", longint'(busy), 0);
        check("reset overflow", longint'(overflow), 0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        run_eval("basic", 3, 4, 5, 6);
        run_eval("negative", -1, -8193, 2, -5);
        run_eval("mul overflow", 200, 56, 256, 0);

        // Held start: runs begin every 6 cycles and clear overflow on accept.
        ops[0] = 1; ops[1] = 1; ops[2] = 1; ops[3] = 1;
        start = 1'b1;
        dcyc.delete();
        for (int c = 0; c < 18; c++) begin
            tick();
            if (c == 12) start = 1'b0;
            if (c == 0) check("held ovf cleared", longint'(overflow), 0);
            if (done) begin
                dcyc.push_back(c);
                check("held result", longint'(result), 1);
                check("held overflow", longint'(overflow), 0);
            end
        end
        check("held done count", longint'(dcyc.size()), 3);
        if (dcyc.size() == 3) begin
            check("held first done", longint'(dcyc[0]), 4);
            check("held gap 1", longint'(dcyc[1] - dcyc[0]), 6);
            check("held gap 2", longint'(dcyc[2] - dcyc[1]), 6);
        end
        for (int c = 0; c < 3; c++) tick();

        // Start pulses at E0 and E2: only one run should result.
        ops[0] = 7; ops[1] = 2; ops[2] = 3; ops[3] = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        dcount = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) begin
                dcount++;
                check("busy-start result", longint'(result), 26);
            end
            tick();
        end
        check("busy-start done count", longint'(dcount), 1);

        // Asynchronous reset while in MUL_C.
        ops[0] = 9; ops[1] = 9; ops[2] = 9; ops[3] = 9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre-reset select", longint'(select), 2);
        #2 reset = 1'b1;
        #1;
        check("async result", longint'(result), 0);
        check("async select", longint'(select), 0);
        check("async busy", longint'(busy), 0);
        check("async done", longint'(done), 0);
        check("async overflow", longint'(overflow), 0);
        @(negedge clock);
        reset = 1'b0;
        dcount = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done) dcount++;
        end
        check("no done after reset", longint'(dcount), 0);
        run_eval("after reset", 3, 4, 5, 6);

        // Random operands, mixing small values with full-range ones.
        for (int n = 0; n < 24; n++) begin
            if (n % 2 == 0) begin
                ra = longint'($urandom_range(0, 400)) - 200;
                rb = longint'($urandom_range(0, 400)) - 200;
                rc = longint'($urandom_range(0, 200)) - 100;
                rd = longint'($urandom_range(0, 400)) - 200;
            end else begin
                ra = longint'($urandom_range(0, 65535)) + C_MIN;
                rb = longint'($urandom_range(0, 65535)) + C_MIN;
                rc = longint'($urandom_range(0, 65535)) + C_MIN;
                rd = longint'($urandom_range(0, 65535)) + C_MIN;
            end
            run_eval("random", ra, rb, rc, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
